// File: rtl/pipe_seq_ctrl.sv
// Pipeline sequencing controller: start/halt FSM, per-stage valid bits with stall-freeze and
// flush-bubble propagation, drain-on-halt, and saturating cycle/retire performance counters.
module pipe_seq_ctrl #(
    parameter int STAGES    = 5,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 halt_req,
    input  logic [STAGES-1:0]    stall_req,
    input  logic [STAGES-1:0]    flush_req,
    output logic                 fetch_en,
    output logic [STAGES-1:0]    stage_en,
    output logic [STAGES-1:0]    stage_valid,
    output logic                 stop,
    output logic [1:0]           state,
    output logic [CNT_WIDTH-1:0] cycle_cnt,
    output logic [CNT_WIDTH-1:0] retire_cnt
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        HALT  = 2'd3
    } state_t;

    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    state_t              cur_state;
    state_t              nxt_state;
    logic [STAGES-1:0]   frozen;
    logic [STAGES-1:0]   valid_nxt;
    logic                active;
    logic                run_entry;
    logic                retire;

    // A stall at stage j freezes j and every stage upstream of it.
    always_comb begin
        logic acc;
        acc    = 1'b0;
        frozen = '0;
        for (int k = STAGES - 1; k >= 0; k--) begin
            acc       = acc | stall_req[k];
            frozen[k] = acc;
        end
    end

    // NOTE: every signal driven here gets a default first, so no path can leave it unassigned and infer a latch.
    always_comb begin
        nxt_state = cur_state;
        case (cur_state)
            IDLE:    if (start)               nxt_state = RUN;
            RUN:     if (halt_req)            nxt_state = DRAIN;
            DRAIN:   if (stage_valid == '0)   nxt_state = HALT;
            HALT:    if (start)               nxt_state = RUN;
            default:                          nxt_state = IDLE;
        endcase
    end

    assign active    = (cur_state == RUN) || (cur_state == DRAIN);
    assign run_entry = ((cur_state == IDLE) || (cur_state == HALT)) && (nxt_state == RUN);
    assign fetch_en  = (cur_state == RUN) && !halt_req && !frozen[0];
    assign stage_en  = active ? ~frozen : '0;
    assign retire    = active && stage_valid[STAGES-1] && !frozen[STAGES-1] && !flush_req[STAGES-1];
    assign state     = cur_state;

    // Flush beats freeze; a stage just below a frozen one receives a bubble.
    always_comb begin
        valid_nxt = stage_valid;
        if (active) begin
            if (flush_req[0])    valid_nxt[0] = 1'b0;
            else if (!frozen[0]) valid_nxt[0] = fetch_en;
            for (int k = 1; k < STAGES; k++) begin
                if (flush_req[k])        valid_nxt[k] = 1'b0;
                else if (frozen[k])      valid_nxt[k] = stage_valid[k];
                else if (frozen[k-1])    valid_nxt[k] = 1'b0;
                else                     valid_nxt[k] = stage_valid[k-1];
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cur_state   <= IDLE;
            stage_valid <= '0;
            stop        <= 1'b0;
            cycle_cnt   <= '0;
            retire_cnt  <= '0;
        end else begin
            cur_state   <= nxt_state;
            stage_valid <= valid_nxt;
            stop        <= (nxt_state == HALT);
            if (run_entry) begin
                cycle_cnt  <= '0;
                retire_cnt <= '0;
            end else begin
                if (active && cycle_cnt != CNT_MAX)
                    cycle_cnt <= cycle_cnt + CNT_ONE;
                if (retire && retire_cnt != CNT_MAX)
                    retire_cnt <= retire_cnt + CNT_ONE;
            end
        end
    end

endmodule

// File: tb/tb_pipe_seq_ctrl.sv
// Testbench for pipe_seq_ctrl: table of per-cycle vectors with scoreboard queue, a 4-bit-counter
// instance sharing the same stimulus for saturation, and a hand-written mid-run reset sequence.
module tb_pipe_seq_ctrl;

    localparam int S  = 5;
    localparam int NV = 38;

    logic         clk;
    logic         rst;
    logic         start;
    logic         halt_req;
    logic [S-1:0] stall_req;
    logic [S-1:0] flush_req;

    logic         fetch_en,  fetch_en4;
    logic [S-1:0] stage_en,  stage_en4;
    logic [S-1:0] stage_valid, stage_valid4;
    logic         stop, stop4;
    logic [1:0]   state, state4;
    logic [15:0]  cycle_cnt, retire_cnt;
    logic [3:0]   cycle_cnt4, retire_cnt4;

    pipe_seq_ctrl #(.STAGES(S), .CNT_WIDTH(16)) dut (
        .clk(clk), .rst(rst), .start(start), .halt_req(halt_req),
        .stall_req(stall_req), .flush_req(flush_req),
        .fetch_en(fetch_en), .stage_en(stage_en), .stage_valid(stage_valid),
        .stop(stop), .state(state), .cycle_cnt(cycle_cnt), .retire_cnt(retire_cnt)
    );

    pipe_seq_ctrl #(.STAGES(S), .CNT_WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .start(start), .halt_req(halt_req),
        .stall_req(stall_req), .flush_req(flush_req),
        .fetch_en(fetch_en4), .stage_en(stage_en4), .stage_valid(stage_valid4),
        .stop(stop4), .state(state4), .cycle_cnt(cycle_cnt4), .retire_cnt(retire_cnt4)
    );

    typedef struct {
        logic         start;
        logic         halt;
        logic [S-1:0] stall;
        logic [S-1:0] flush;
        logic         fe;
        logic [S-1:0] en;
        logic [S-1:0] valid;
        logic [1:0]   st;
        logic         stp;
        int           cyc;
        int           ret;
    } vec_t;

    vec_t vecs [NV];
    vec_t sb_q [$];
    int   errors = 0;
    int   checks = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic st_in, input logic hl, input logic [S-1:0] stl,
                                input logic [S-1:0] fl, input logic fe, input logic [S-1:0] en,
                                input logic [S-1:0] val, input logic [1:0] st, input logic stp,
                                input int cyc, input int ret);
        vec_t v;
        v.start = st_in; v.halt = hl; v.stall = stl; v.flush = fl;
        v.fe = fe; v.en = en; v.valid = val; v.st = st; v.stp = stp;
        v.cyc = cyc; v.ret = ret;
        return v;
    endfunction

    function automatic int sat4(input int x);
        return (x > 15) ? 15 : x;
    endfunction

    task automatic run_vec(input int i);
        vec_t e;
        @(negedge clk);
        start     = vecs[i].start;
        halt_req  = vecs[i].halt;
        stall_req = vecs[i].stall;
        flush_req = vecs[i].flush;
        #1;
        check($sformatf("v%0d fetch_en", i), 32'(fetch_en), 32'(vecs[i].fe));
        check($sformatf("v%0d stage_en", i), 32'(stage_en), 32'(vecs[i].en));
        sb_q.push_back(vecs[i]);
        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL v%0d scoreboard: got empty queue expected one entry", i);
        end else begin
            e = sb_q.pop_front();
            check($sformatf("v%0d stage_valid", i), 32'(stage_valid), 32'(e.valid));
            check($sformatf("v%0d state", i), 32'(state), 32'(e.st));
            check($sformatf("v%0d stop", i), 32'(stop), 32'(e.stp));
            check($sformatf("v%0d cycle_cnt", i), 32'(cycle_cnt), e.cyc);
            check($sformatf("v%0d retire_cnt", i), 32'(retire_cnt), e.ret);
            check($sformatf("v%0d cycle_cnt4", i), 32'(cycle_cnt4), sat4(e.cyc));
            check($sformatf("v%0d retire_cnt4", i), 32'(retire_cnt4), sat4(e.ret));
        end
    endtask

    initial begin
        rst = 1'b0; start = 1'b0; halt_req = 1'b0; stall_req = '0; flush_req = '0;
        #1;
        check("reset state", 32'(state), 0);
        check("reset valid", 32'(stage_valid), 0);
        check("reset stop", 32'(stop), 0);
        check("reset cycle_cnt", 32'(cycle_cnt), 0);
        repeat (2) @(negedge clk);
        rst = 1'b1;

        //            start halt stall    flush   | fe en       | valid    st  stop cyc ret
        vecs[0]  = mk(1, 0, 5'b00000, 5'b00000, 0, 5'b00000, 5'b00000, 1, 0,  0,  0);
        vecs[1]  = mk(0, 0, 5'b00000, 5'b00000, 1, 5'b11111, 5'b00001, 1, 0,  1,  0);
        vecs[2]  = mk(0, 0, 5'b00000, 5'b00000, 1, 5'b11111, 5'b00011, 1, 0,  2,  0);
        vecs[3]  = mk(0, 0, 5'b00000, 5'b00000, 1, 5'b11111, 5'b00111, 1, 0,  3,  0);
        vecs[4]  = mk(0, 0, 5'b00000, 5'b00000, 1, 5'b11111, 5'b01111, 1, 0,  4,  0);
        vecs[5]  = mk(0, 0, 5'b00000, 5'b00000, 1, 5'b11111, 5'b11111, 1, 0,  5,  0);
        vecs[6]  = mk(0, 0, 5'b00000, 5'b00000, 1, 5'b11111, 5'b11111, 1, 0,  6,  1);
        // stall at stage 2: upstream frozen, bubble into stage 3, retire gap two edges later
        vecs[7]  = mk(0, 0, 5'b00100, 5'b00000, 0, 5'b11000, 5'b10111, 1, 0,  7,  2);
        vecs[8]  = mk(0, 0, 5'b00000, 5'b00000, 1, 5'b11111, 5'b01111, 1, 0,  8,  3);
        vecs[9]  = mk(0, 0, 5'b00000, 5'b00000, 1, 5'b11111, 5'b11111, 1, 0,  9,  3);
        // flush of stages 0..1, then flush combined with stall at stage 1
        vecs[10] = mk(0, 0, 5'b00000, 5'b00011, 1, 5'b11111, 5'b11100, 1, 0, 10,  4);
        vecs[11] = mk(0, 0, 5'b00000, 5'b00000, 1, 5'b11111, 5'b11001, 1, 0, 11,  5);
        vecs[12] = mk(0, 0, 5'b00010, 5'b00011, 0, 5'b11100, 5'b10000, 1, 0, 12,  6);
        vecs[13] = mk(0, 0, 5'b00000, 5'b00000, 1, 5'b11111, 5'b00001, 1, 0, 13,  7);
        vecs[14] = mk(0, 0, 5'b00000, 5'b00000, 1, 5'b11111, 5'b00011, 1, 0, 14,  7);
        vecs[15] = mk(0, 0, 5'b00000, 5'b00000, 1, 5'b11111, 5'b00111, 1, 0, 15,  7);
        vecs[16] = mk(0, 0, 5'b00000, 5'b00000, 1, 5'b11111, 5'b01111, 1, 0, 16,  7);
        vecs[17] = mk(0, 0, 5'b00000, 5'b00000, 1, 5'b11111, 5'b11111, 1, 0, 17,  7);
        // halt on a full pipe: four more retires, stop five edges after the halt edge
        vecs[18] = mk(0, 1, 5'b00000, 5'b00000, 0, 5'b11111, 5'b11110, 2, 0, 18,  8);
        vecs[19] = mk(0, 0, 5'b00000, 5'b00000, 0, 5'b11111, 5'b11100, 2, 0, 19,  9);
        vecs[20] = mk(1, 0, 5'b00000, 5'b00000, 0, 5'b11111, 5'b11000, 2, 0, 20, 10);
        vecs[21] = mk(0, 1, 5'b00000, 5'b00000, 0, 5'b11111, 5'b10000, 2, 0, 21, 11);
        vecs[22] = mk(0, 0, 5'b00000, 5'b00000, 0, 5'b11111, 5'b00000, 2, 0, 22, 12);
        vecs[23] = mk(0, 0, 5'b00000, 5'b00000, 0, 5'b11111, 5'b00000, 3, 1, 23, 12);
        vecs[24] = mk(0, 0, 5'b00000, 5'b00000, 0, 5'b00000, 5'b00000, 3, 1, 23, 12);
        vecs[25] = mk(0, 1, 5'b11111, 5'b00000, 0, 5'b00000, 5'b00000, 3, 1, 23, 12);
        // restart from HALT clears both counters; halt with concurrent flush of stage 1
        vecs[26] = mk(1, 0, 5'b00000, 5'b00000, 0, 5'b00000, 5'b00000, 1, 0,  0,  0);
        vecs[27] = mk(0, 0, 5'b00000, 5'b00000, 1, 5'b11111, 5'b00001, 1, 0,  1,  0);
        vecs[28] = mk(0, 1, 5'b00000, 5'b00010, 0, 5'b11111, 5'b00000, 2, 0,  2,  0);
        vecs[29] = mk(0, 0, 5'b00000, 5'b00000, 0, 5'b11111, 5'b00000, 3, 1,  3,  0);
        // refill, then a stall on the last stage blocks the retire of a valid instruction
        vecs[30] = mk(1, 0, 5'b00000, 5'b00000, 0, 5'b00000, 5'b00000, 1, 0,  0,  0);
        vecs[31] = mk(0, 0, 5'b00000, 5'b00000, 1, 5'b11111, 5'b00001, 1, 0,  1,  0);
        vecs[32] = mk(0, 0, 5'b00000, 5'b00000, 1, 5'b11111, 5'b00011, 1, 0,  2,  0);
        vecs[33] = mk(0, 0, 5'b00000, 5'b00000, 1, 5'b11111, 5'b00111, 1, 0,  3,  0);
        vecs[34] = mk(0, 0, 5'b00000, 5'b00000, 1, 5'b11111, 5'b01111, 1, 0,  4,  0);
        vecs[35] = mk(0, 0, 5'b00000, 5'b00000, 1, 5'b11111, 5'b11111, 1, 0,  5,  0);
        vecs[36] = mk(0, 0, 5'b10000, 5'b00000, 0, 5'b00000, 5'b11111, 1, 0,  6,  0);
        vecs[37] = mk(0, 0, 5'b00000, 5'b00000, 1, 5'b11111, 5'b11111, 1, 0,  7,  1);

        for (int i = 0; i < NV; i++) run_vec(i);

        // asynchronous reset mid-RUN with a full pipe takes effect before the next edge
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("async rst state", 32'(state), 0);
        check("async rst valid", 32'(stage_valid), 0);
        check("async rst stop", 32'(stop), 0);
        check("async rst cycle_cnt", 32'(cycle_cnt), 0);
        check("async rst retire_cnt", 32'(retire_cnt), 0);
        check("async rst retire_cnt4", 32'(retire_cnt4), 0);
        check("async rst stage_en", 32'(stage_en), 0);
        check("async rst fetch_en", 32'(fetch_en), 0);
        @(posedge clk);
        #1;
        check("held rst retire_cnt", 32'(retire_cnt), 0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("post rst state", 32'(state), 0);
        check("post rst valid", 32'(stage_valid), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
